// File: rtl/tick_div.sv
// Multi-channel programmable tick generator: one-cycle strobe every N+1 cycles per channel.
// Define TICK_DIV_FRAC_EN to add a 16-bit fractional increment per channel (wr_frac port).
module tick_div #(
  parameter int unsigned NCH            = 4,
  parameter int unsigned CW             = 20,
  parameter int unsigned DEFAULT_PERIOD = 833333,
  localparam int unsigned ChW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           wr_en,
  input  logic [ChW-1:0] wr_ch,
  input  logic [CW-1:0]  wr_period,
`ifdef TICK_DIV_FRAC_EN
  input  logic [15:0]    wr_frac,
`endif
  output logic [NCH-1:0] tick
);

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] per_q, per_d;
    logic [CW-1:0] pend_q, pend_d;
    logic          pv_q, pv_d;
    logic          tick_q, tick_d;
    logic          wr_hit;
    logic          stretch;
    logic [CW-1:0] wrap_per;
    logic [CW-1:0] sync_per;

    // Out-of-range wr_ch values match no channel and are dropped.
    assign wr_hit   = wr_en && (32'(wr_ch) == ch);
    // A write landing on the wrap edge takes effect at that wrap.
    assign wrap_per = wr_hit ? wr_period : (pv_q ? pend_q : per_q);
    assign sync_per = pv_q ? pend_q : per_q;

`ifdef TICK_DIV_FRAC_EN
    logic [15:0] frac_q, frac_d;
    logic [15:0] fpend_q, fpend_d;
    logic [15:0] acc_q, acc_d;
    logic        x_q, x_d;
    logic [15:0] wrap_frac;

    assign wrap_frac = wr_hit ? wr_frac : (pv_q ? fpend_q : frac_q);
    assign stretch   = x_q;
`else
    assign stretch   = 1'b0;
`endif

    always_comb begin
      cnt_d  = cnt_q;
      per_d  = per_q;
      pend_d = pend_q;
      pv_d   = pv_q;
      tick_d = 1'b0;
`ifdef TICK_DIV_FRAC_EN
      frac_d  = frac_q;
      fpend_d = fpend_q;
      acc_d   = acc_q;
      x_d     = x_q;
`endif
      if (wr_hit) begin
        pend_d = wr_period;
        pv_d   = 1'b1;
`ifdef TICK_DIV_FRAC_EN
        fpend_d = wr_frac;
`endif
      end

      if (sync) begin
        cnt_d = '0;
        per_d = sync_per;
        pv_d  = wr_hit;
`ifdef TICK_DIV_FRAC_EN
        frac_d = pv_q ? fpend_q : frac_q;
        acc_d  = '0;
        x_d    = 1'b0;
`endif
      end else if (!en[ch]) begin
        // Frozen: counter and pending state hold, phase is preserved.
      end else if ((cnt_q == per_q) && stretch) begin
        // Carry from the accumulator: spend one extra cycle before the wrap.
`ifdef TICK_DIV_FRAC_EN
        x_d = 1'b0;
`endif
      end else if (cnt_q == per_q) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        per_d  = wrap_per;
        pv_d   = 1'b0;
`ifdef TICK_DIV_FRAC_EN
        frac_d       = wrap_frac;
        {x_d, acc_d} = 17'(acc_q) + 17'(wrap_frac);
`endif
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q  <= '0;
        per_q  <= CW'(DEFAULT_PERIOD);
        pend_q <= '0;
        pv_q   <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        pend_q <= pend_d;
        pv_q   <= pv_d;
        tick_q <= tick_d;
      end
    end

`ifdef TICK_DIV_FRAC_EN
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        frac_q  <= '0;
        fpend_q <= '0;
        acc_q   <= '0;
        x_q     <= 1'b0;
      end else begin
        frac_q  <= frac_d;
        fpend_q <= fpend_d;
        acc_q   <= acc_d;
        x_q     <= x_d;
      end
    end
`endif

    assign tick[ch] = tick_q;
  end

endmodule
